// File: rtl/tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter
//
// Round-robin arbiter and enable sequencer for a shared tri-state bus driven
// by up to 8 tri-state buffers. Exactly one requester owns the bus at a time,
// and every change of owner is separated by an all-disabled turnaround gap of
// TA cycles, so two drivers can never be enabled in the same cycle.
//
// Parameters:
//   N        number of requesters / tri-state drivers (2..8)
//   TA       turnaround cycles with all enables low between owners (1..15)
//   MAX_HOLD max consecutive owned cycles before preemption (2..255),
//            only meaningful when the timeout feature is built in
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       per-requester level request, held high while the bus is needed
//   en        registered one-hot (or zero) enable, bit i drives buffer i
//   owner_id  index of the current owner while bus_busy=1, otherwise 0
//   bus_busy  high while any en bit is high
//   preempt   one-cycle pulse when an owner is revoked by the hold timeout
//
// Build option:
//   TRI_BUS_TIMEOUT_EN  when defined, an owner that has held the bus for
//                       MAX_HOLD cycles while someone else is waiting is
//                       revoked. When undefined, owners hold indefinitely and
//                       preempt is tied low.
// ---------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int TA       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 bus_busy,
    output logic                 preempt
);

    localparam int ID_W = $clog2(N);

    // Turnaround counter is loaded with TA-1 so the decision edge lands
    // exactly TA edges after the release edge.
    localparam logic [3:0]      TA_LAST  = 4'(TA - 1);
    localparam logic [ID_W-1:0] PTR_INIT = ID_W'(N - 1);
    localparam logic [N-1:0]    EN_ONE   = N'(1);

    // Elaboration-time parameter range checks.
    if (N < 2 || N > 8) begin : g_bad_n
        $error("tri_bus_arbiter: N must be in 2..8");
    end
    if (TA < 1 || TA > 15) begin : g_bad_ta
        $error("tri_bus_arbiter: TA must be in 1..15");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("tri_bus_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [N-1:0]    en_n;
    logic [ID_W-1:0] owner_n;
    logic            busy_n;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_n;
    logic [3:0]      ta_cnt;
    logic [3:0]      ta_n;

    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] hi_win;
    logic [ID_W-1:0] lo_win;
    logic            hi_hit;
    logic            any_req;
    logic            owner_req;
    logic            do_grant;
    logic            do_revoke;

`ifdef TRI_BUS_TIMEOUT_EN
    localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);

    logic [7:0] hold_cnt;
    logic [7:0] hold_n;
    logic [8:0] hold_inc;
    logic       other_req;
    logic       preempt_n;
`endif

    assign any_req = |req;

    // While owning, en is the one-hot mask of the owner, so masking req with
    // en isolates the owner's own request without a variable bit select.
    assign owner_req = |(req & en);

`ifdef TRI_BUS_TIMEOUT_EN
    assign other_req = |(req & ~en);
`endif

    // Round-robin winner: the lowest set index above ptr if there is one,
    // otherwise the lowest set index overall (the wrap-around case). Scanning
    // downward lets the last hit be the lowest index.
    always_comb begin
        hi_hit = 1'b0;
        hi_win = '0;
        lo_win = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (ID_W'(j) > ptr) begin
                    hi_hit = 1'b1;
                    hi_win = ID_W'(j);
                end
                lo_win = ID_W'(j);
            end
        end
        winner = hi_hit ? hi_win : lo_win;
    end

    // Next-state and next-output logic. The case statement only decides
    // whether to grant or revoke; the register updates for those two events
    // are applied once below so en, owner_id and bus_busy always move together.
    always_comb begin
        state_n   = state;
        en_n      = en;
        owner_n   = owner_id;
        busy_n    = bus_busy;
        ptr_n     = ptr;
        ta_n      = ta_cnt;
        do_grant  = 1'b0;
        do_revoke = 1'b0;
`ifdef TRI_BUS_TIMEOUT_EN
        hold_n    = hold_cnt;
        hold_inc  = {1'b0, hold_cnt} + 9'd1;
        preempt_n = 1'b0;
`endif

        case (state)
            IDLE: begin
                do_grant = any_req;
            end

            OWN: begin
                // A release always wins over a timeout in the same cycle.
                if (!owner_req) begin
                    do_revoke = 1'b1;
                end
`ifdef TRI_BUS_TIMEOUT_EN
                else if (hold_inc >= HOLD_LIM && other_req) begin
                    do_revoke = 1'b1;
                    preempt_n = 1'b1;
                end else if (hold_inc <= HOLD_LIM) begin
                    // Saturate at MAX_HOLD so a lone owner can hold forever
                    // and is revoked on the first edge someone else asks.
                    hold_n = hold_inc[7:0];
                end
`endif
            end

            TURN: begin
                if (ta_cnt == 4'd0) begin
                    if (any_req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    ta_n = ta_cnt - 4'd1;
                end
            end

            default: begin
                state_n = IDLE;
                en_n    = '0;
                owner_n = '0;
                busy_n  = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_n = OWN;
            en_n    = EN_ONE << winner;
            owner_n = winner;
            busy_n  = 1'b1;
            ptr_n   = winner;
`ifdef TRI_BUS_TIMEOUT_EN
            hold_n  = '0;
`endif
        end

        // ptr is left at the revoked index so that requester has the lowest
        // priority at the end of the turnaround.
        if (do_revoke) begin
            state_n = TURN;
            en_n    = '0;
            owner_n = '0;
            busy_n  = 1'b0;
            ta_n    = TA_LAST;
        end
    end

    // State and output registers. Reset is asynchronous so en drops the
    // moment rst_n falls, even in the middle of an ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            en       <= '0;
            owner_id <= '0;
            bus_busy <= 1'b0;
            ptr      <= PTR_INIT;
            ta_cnt   <= '0;
        end else begin
            state    <= state_n;
            en       <= en_n;
            owner_id <= owner_n;
            bus_busy <= busy_n;
            ptr      <= ptr_n;
            ta_cnt   <= ta_n;
        end
    end

`ifdef TRI_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            hold_cnt <= hold_n;
            preempt  <= preempt_n;
        end
    end
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tri_bus_arbiter
//
// Directed bench for tri_bus_arbiter. Two instances share clock and reset:
// dut (N=4, TA=1, MAX_HOLD=8) and dut3 (N=4, TA=3). Each check compares the
// packed output vector {en, owner_id, bus_busy, preempt} against a
// hand-computed value. The timeout section follows TRI_BUS_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req3;

    logic [3:0] en;
    logic [1:0] owner_id;
    logic       bus_busy;
    logic       preempt;

    logic [3:0] en3;
    logic [1:0] owner_id3;
    logic       bus_busy3;
    logic       preempt3;

    logic [7:0] obs1;
    logic [7:0] obs3;

    int vectors     = 0;
    int miscompares = 0;

    assign obs1 = {en, owner_id, bus_busy, preempt};
    assign obs3 = {en3, owner_id3, bus_busy3, preempt3};

    tri_bus_arbiter #(.N(4), .TA(1), .MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .en       (en),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    tri_bus_arbiter #(.N(4), .TA(3), .MAX_HOLD(8)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req3),
        .en       (en3),
        .owner_id (owner_id3),
        .bus_busy (bus_busy3),
        .preempt  (preempt3)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ev(input logic [3:0] e, input logic [1:0] id,
                                      input logic b, input logic p);
        return {e, id, b, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] r3);
        req  = r;
        req3 = r3;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed en/id/busy/pre=%b_%b_%b_%b expected=%b_%b_%b_%b",
                   tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Bus invariants on both instances: never two enables, busy mirrors en,
    // owner_id reads 0 whenever the bus is free.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert ($onehot0(en) && (bus_busy === |en) && (bus_busy || owner_id === 2'd0)) else begin
                miscompares++;
                $error("[TB] FAIL invariant dut: en=%b busy=%b id=%0d", en, bus_busy, owner_id);
            end
            assert ($onehot0(en3) && (bus_busy3 === |en3) && (bus_busy3 || owner_id3 === 2'd0)) else begin
                miscompares++;
                $error("[TB] FAIL invariant dut3: en=%b busy=%b id=%0d", en3, bus_busy3, owner_id3);
            end
        end
    end

    initial begin
        logic [3:0] oh_prev;
        logic [3:0] oh_next;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000);
        tick();
        tick();
        checkOutput("reset dut", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        checkOutput("reset dut3", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        checkOutput("idle after reset", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // ---------------- round robin, TA=1 ----------------
        applyStimulus(4'b1111, 4'b0000);
        tick();
        checkOutput("rr grant 0", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            oh_prev = 4'b0001 << ((k - 1) % 4);
            oh_next = 4'b0001 << (k % 4);
            tick();
            checkOutput($sformatf("rr hold %0d", k), obs1, ev(oh_prev, 2'((k - 1) % 4), 1'b1, 1'b0));
            applyStimulus(4'b1111 & ~oh_prev, 4'b0000);
            tick();
            checkOutput($sformatf("rr gap %0d", k), obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
            applyStimulus(4'b1111, 4'b0000);
            tick();
            checkOutput($sformatf("rr grant %0d", k % 4), obs1, ev(oh_next, 2'(k % 4), 1'b1, 1'b0));
        end
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("rr release", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("rr idle", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // ---------------- single grant / release ----------------
        applyStimulus(4'b0010, 4'b0000);
        tick();
        checkOutput("single grant 1", obs1, ev(4'b0010, 2'd1, 1'b1, 1'b0));
        tick();
        tick();
        tick();
        checkOutput("single hold", obs1, ev(4'b0010, 2'd1, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("single release", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("single idle", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("grant from idle wraps", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0000);
        tick();
        tick();

        // ---------------- asynchronous reset mid-ownership ----------------
        applyStimulus(4'b0100, 4'b0000);
        tick();
        checkOutput("pre-reset own 2", obs1, ev(4'b0100, 2'd2, 1'b1, 1'b0));
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("async reset drop", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("held in reset", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        checkOutput("grant after reset", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0000);
        tick();
        tick();

        // ---------------- turnaround TA=3 on dut3 ----------------
        applyStimulus(4'b0000, 4'b0100);
        tick();
        checkOutput("ta3 grant 2", obs3, ev(4'b0100, 2'd2, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0101);
        tick();
        checkOutput("ta3 others ignored", obs3, ev(4'b0100, 2'd2, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0001);
        tick();
        checkOutput("ta3 gap 1", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("ta3 gap 2", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("ta3 gap 3", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("ta3 grant 0", obs3, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("ta3 release", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        applyStimulus(4'b0000, 4'b1000);
        tick();
        checkOutput("ta3 short req gap", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("ta3 dropped req gap", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("ta3 no grant", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("ta3 idle", obs3, ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // ---------------- hold timeout ----------------
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("to grant 0", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        applyStimulus(4'b1001, 4'b0000);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkOutput($sformatf("to hold %0d", i), obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        tick();
`ifdef TRI_BUS_TIMEOUT_EN
        checkOutput("to preempt", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b1));
        tick();
        checkOutput("to grant 3", obs1, ev(4'b1000, 2'd3, 1'b1, 1'b0));
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("to release 3", obs1, ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        checkOutput("to regrant 0", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
`else
        checkOutput("no-to hold 8", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        tick();
        checkOutput("no-to hold 9", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        applyStimulus(4'b0001, 4'b0000);
        tick();
        checkOutput("no-to hold 10", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        tick();
        checkOutput("no-to hold 11", obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
`endif
        for (int i = 0; i < 50; i++) begin
            tick();
            checkOutput($sformatf("lone owner %0d", i), obs1, ev(4'b0001, 2'd0, 1'b1, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
